instr_fetch_unit: RTL and testbench

- Fetch stage of KGPminiRISC: owns the PC, issues word reads to instruction memory over a req/ack handshake, and holds the returned instruction.
- Splits the instruction into fields; opcode and func feed the control unit directly.
- Presents the instruction to decode with a valid/ready handshake.
- Accepts a PC redirect from branch resolution and squashes any wrong-path fetch.

---
 rtl/kgp_isa_pkg.sv | 39 +++
 rtl/ifu_pc_reg.sv | 49 ++++
 rtl/instr_fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_isa_pkg.sv
// -----------------------------------------------------------------------------
// kgp_isa_pkg
// Shared KGPminiRISC ISA definitions: instruction field bit positions, opcode
// constants, the fetch-unit FSM state type and the default PC increment.
// No ports (package).
// -----------------------------------------------------------------------------
package kgp_isa_pkg;

    localparam int unsigned INSTR_W     = 32;

    // Instruction field positions
    localparam int unsigned OPCODE_MSB  = 31;
    localparam int unsigned OPCODE_LSB  = 26;
    localparam int unsigned RS_MSB      = 25;
    localparam int unsigned RS_LSB      = 21;
    localparam int unsigned RT_MSB      = 20;
    localparam int unsigned RT_LSB      = 16;
    localparam int unsigned IMM_MSB     = 15;
    localparam int unsigned IMM_LSB     = 0;
    localparam int unsigned LABEL_MSB   = 25;
    localparam int unsigned LABEL_LSB   = 0;
    localparam int unsigned FUNC_MSB    = 4;
    localparam int unsigned FUNC_LSB    = 0;

    // Opcode constants
    localparam logic [5:0] OP_ALU       = 6'b000000;
    localparam logic [5:0] OP_JUMP      = 6'b001010;
    localparam logic [5:0] OP_CALL      = 6'b001100;

    // Byte distance between sequential instructions
    localparam int unsigned PC_STEP_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } ifu_state_t;

endpackage

// File: rtl/ifu_pc_reg.sv
// -----------------------------------------------------------------------------
// ifu_pc_reg
// Program counter register with its redirect / sequential-increment mux.
// Redirect wins over increment; redirect targets are forced word-aligned.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (pc <= RESET_PC)
//   i_redirect        load i_redirect_pc (low 2 bits cleared)
//   i_redirect_pc     redirect target
//   i_advance         pc <= pc + PC_STEP (wraps modulo 2^ADDR_W)
//   o_pc              current PC
// -----------------------------------------------------------------------------
module ifu_pc_reg
    import kgp_isa_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = PC_STEP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;

    always_comb begin
        w_pc_next = r_pc;
        if (i_redirect) begin
            w_pc_next = i_redirect_pc & ~ADDR_W'(3);
        end else if (i_advance) begin
            w_pc_next = r_pc + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// KGPminiRISC fetch stage. Owns the PC, issues word reads over a req/ack
// handshake, holds the returned instruction for decode (valid/ready) and
// squashes wrong-path fetches on a PC redirect.
// Optional feature macro: IFU_PERF_CNT_EN adds retired/squash counters.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   i_fetch_en                    permits issuing new fetches
//   o_imem_req / o_imem_addr      fetch request and word address
//   i_imem_ack / i_imem_rdata     single-cycle acknowledge with data
//   i_redirect_valid/_pc          taken branch/jump target (one-cycle pulse)
//   o_out_valid / i_out_ready     instruction handshake towards decode
//   o_instr                       held instruction word
//   o_opcode/o_func/o_rs/o_rt/o_imm16/o_label26   instruction fields
//   o_pc_out / o_pc_link          PC of held instruction and PC + PC_STEP
//   o_retired_cnt/o_squash_cnt    (IFU_PERF_CNT_EN only) event counters
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import kgp_isa_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned       PC_STEP  = PC_STEP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_fetch_en,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [31:0]       i_imem_rdata,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [31:0]       o_instr,
    output logic [5:0]        o_opcode,
    output logic [4:0]        o_func,
    output logic [4:0]        o_rs,
    output logic [4:0]        o_rt,
    output logic [15:0]       o_imm16,
    output logic [25:0]       o_label26,
    output logic [ADDR_W-1:0] o_pc_out,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0]       o_retired_cnt,
    output logic [31:0]       o_squash_cnt,
`endif
    output logic [ADDR_W-1:0] o_pc_link
);

    ifu_state_t        r_state;
    logic              r_drop;
    logic [ADDR_W-1:0] r_drop_addr;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_pc_out;

    logic [ADDR_W-1:0] w_pc;
    logic              w_fetch;
    logic              w_hold;
    logic              w_advance;

    assign w_fetch   = (r_state == FETCH);
    assign w_hold    = (r_state == HOLD);
    // Only an accepted (non-dropped) ack moves the PC forward; redirect
    // priority is resolved inside the PC register.
    assign w_advance = w_fetch & i_imem_ack & ~r_drop;

    ifu_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_redirect    (i_redirect_valid),
        .i_redirect_pc (i_redirect_pc),
        .i_advance     (w_advance),
        .o_pc          (w_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_drop      <= 1'b0;
            r_drop_addr <= '0;
            r_instr     <= '0;
            r_pc_out    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_fetch_en) begin
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    if (i_imem_ack) begin
                        if (i_redirect_valid) begin
                            // Data is wrong-path; refetch at the new PC.
                            r_drop  <= 1'b0;
                            r_state <= FETCH;
                        end else if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= i_fetch_en ? FETCH : IDLE;
                        end else begin
                            r_instr  <= i_imem_rdata;
                            r_pc_out <= w_pc;
                            r_state  <= HOLD;
                        end
                    end else if (i_redirect_valid) begin
                        // PC moves on, but the outstanding request must keep
                        // its original address until the memory acks it.
                        if (!r_drop) begin
                            r_drop_addr <= w_pc;
                        end
                        r_drop <= 1'b1;
                    end
                end
                HOLD: begin
                    if (i_redirect_valid || i_out_ready) begin
                        r_state <= i_fetch_en ? FETCH : IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_imem_req  = w_fetch;
    assign o_imem_addr = r_drop ? r_drop_addr : w_pc;
    // A redirect squashes the held instruction in the same cycle.
    assign o_out_valid = w_hold & ~i_redirect_valid;

    assign o_instr   = r_instr;
    assign o_opcode  = r_instr[OPCODE_MSB:OPCODE_LSB];
    assign o_func    = r_instr[FUNC_MSB:FUNC_LSB];
    assign o_rs      = r_instr[RS_MSB:RS_LSB];
    assign o_rt      = r_instr[RT_MSB:RT_LSB];
    assign o_imm16   = r_instr[IMM_MSB:IMM_LSB];
    assign o_label26 = r_instr[LABEL_MSB:LABEL_LSB];
    assign o_pc_out  = r_pc_out;
    assign o_pc_link = r_pc_out + ADDR_W'(PC_STEP);

`ifdef IFU_PERF_CNT_EN
    logic        w_retire;
    logic        w_squash;
    logic [31:0] r_retired_cnt;
    logic [31:0] r_squash_cnt;

    assign w_retire = o_out_valid & i_out_ready;
    // Squash: held instruction killed, or ack data thrown away.
    assign w_squash = (w_hold & i_redirect_valid)
                    | (w_fetch & i_imem_ack & (r_drop | i_redirect_valid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired_cnt <= '0;
            r_squash_cnt  <= '0;
        end else begin
            if (w_retire) begin
                r_retired_cnt <= r_retired_cnt + 32'd1;
            end
            if (w_squash) begin
                r_squash_cnt <= r_squash_cnt + 32'd1;
            end
        end
    end

    assign o_retired_cnt = r_retired_cnt;
    assign o_squash_cnt  = r_squash_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Bench for instr_fetch_unit: directed scenarios followed by a randomized run
// checked against a program-order model (next expected PC, retarget on
// redirect). An instruction memory responder with configurable ack latency
// answers requests. Define IFU_PERF_CNT_EN to also check the counters.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm16;
    logic [25:0] label26;
    logic [31:0] pc_out;
    logic [31:0] pc_link;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] retired_cnt;
    logic [31:0] squash_cnt;
`endif

    instr_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (RESET_PC),
        .PC_STEP  (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_fetch_en       (fetch_en),
        .o_imem_req       (imem_req),
        .o_imem_addr      (imem_addr),
        .i_imem_ack       (imem_ack),
        .i_imem_rdata     (imem_rdata),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_out_valid      (out_valid),
        .i_out_ready      (out_ready),
        .o_instr          (instr),
        .o_opcode         (opcode),
        .o_func           (func),
        .o_rs             (rs),
        .o_rt             (rt),
        .o_imm16          (imm16),
        .o_label26        (label26),
        .o_pc_out         (pc_out),
`ifdef IFU_PERF_CNT_EN
        .o_retired_cnt    (retired_cnt),
        .o_squash_cnt     (squash_cnt),
`endif
        .o_pc_link        (pc_link)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory responder configuration
    int mem_mode = 0;
    int ack_lat  = 0;
    bit rand_lat = 1'b0;
    int wait_cnt = 0;
    int cur_lat  = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input int mode);
        if (mode == 0) return a | 32'h0C00_0000;
        if (mode == 1) return 32'h0000_0001;
        return {a[15:0] ^ 16'hA5C3, a[15:0] ^ 16'h3C0F};
    endfunction

    // Instruction memory: acks a pending request after cur_lat idle cycles.
    always @(negedge clk) begin
        if (!rst_n || !imem_req || imem_ack) begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            wait_cnt   = 0;
            cur_lat    = rand_lat ? int'($urandom_range(0, 3)) : ack_lat;
        end else if (wait_cnt >= cur_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr, mem_mode);
        end else begin
            wait_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are driven just after the falling edge, outputs sampled 1 later.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [31:0] addrs[3];
    logic [31:0] ackq[$];
    logic [31:0] exp_pc;
    logic [31:0] ew;
    logic [31:0] got_pc;
    logic [31:0] got_instr;
    logic [31:0] prev_addr;
    logic        prev_req;
    logic        prev_ack;
    bit          found;
    int          na;
    int          nh;

    initial begin
        // ---------------- Reset state ----------------
        do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_imem_req", imem_req, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_pc_out", pc_out, 0);
        check("rst_pc_link", pc_link, 32'h4);
        rst_n = 1'b1;
        step();
        step();
        check("idle_no_req", imem_req, 0);

        // ---------------- Sequential fetch, zero-wait memory ----------------
        mem_mode  = 0;
        ack_lat   = 0;
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        na = 0;
        nh = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            #1;
            if (imem_req && imem_ack && na < 3) begin
                addrs[na] = imem_addr;
                na++;
            end
            if (out_valid && out_ready && nh < 3) begin
                check("seq_pc_out", pc_out, 32'(nh * 4));
                check("seq_pc_link", pc_link, 32'(nh * 4 + 4));
                check("seq_opcode", opcode, 6'b000011);
                nh++;
            end
        end
        check("seq_n_req", na, 3);
        check("seq_n_out", nh, 3);
        for (int i = 0; i < 3; i++) check("seq_addr", addrs[i], 32'(i * 4));

        // ---------------- Stall: out_ready low ----------------
        do_reset();
        mem_mode = 1;
        fetch_en = 1'b1;
        found    = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            #1;
            found = out_valid;
        end
        check("stall_reach_hold", found, 1);
        check("stall_pc_out", pc_out, RESET_PC);
        for (int c = 0; c < 5; c++) begin
            step();
            #1;
            check("stall_valid", out_valid, 1);
            check("stall_instr", instr, 32'h1);
            check("stall_opcode", opcode, 0);
            check("stall_func", func, 1);
            check("stall_no_req", imem_req, 0);
        end

        // ---------------- Redirect in HOLD ----------------
        step();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        #1;
        check("hold_redir_masked", out_valid, 0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("hold_redir_req", imem_req, 1);
        check("hold_redir_addr", imem_addr, 32'h40);

        // ---------------- Redirect with request outstanding ----------------
        mem_mode = 0;
        ack_lat  = 4;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        step();
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            step();
            #1;
            found = imem_req && (imem_addr == 32'h10) && !imem_ack;
        end
        check("drop_reach_0x10", found, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        step();
        redirect_valid = 1'b0;
        #1;
        check("drop_req_held", imem_req, 1);
        check("drop_addr_held", imem_addr, 32'h10);
        ackq.delete();
        found     = 1'b0;
        got_pc    = '0;
        got_instr = '0;
        for (int c = 0; c < 30 && !found; c++) begin
            if (c > 0) begin
                step();
                #1;
            end
            if (imem_req && imem_ack) ackq.push_back(imem_addr);
            if (out_valid && out_ready) begin
                found     = 1'b1;
                got_pc    = pc_out;
                got_instr = instr;
            end
        end
        check("drop_handshake", found, 1);
        check("drop_n_acks", ackq.size(), 2);
        check("drop_ack0_addr", (ackq.size() > 0) ? ackq[0] : 32'hX, 32'h10);
        check("drop_ack1_addr", (ackq.size() > 1) ? ackq[1] : 32'hX, 32'h80);
        check("drop_pc_out", got_pc, 32'h80);
        check("drop_instr", got_instr, 32'h0C00_0080);

        // ---------------- Reset mid-FETCH ----------------
        ack_lat = 6;
        found   = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            #1;
            found = imem_req && !imem_ack;
        end
        check("midrst_pending", found, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_req_low", imem_req, 0);
        check("midrst_valid_low", out_valid, 0);
        ack_lat = 0;
        step();
        step();
        rst_n = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            step();
            #1;
            if (imem_req) begin
                found = 1'b1;
                check("midrst_first_addr", imem_addr, RESET_PC);
            end
        end
        check("midrst_refetch", found, 1);

        // ---------------- Randomized run vs program-order model ----------------
        do_reset();
        mem_mode = 2;
        rand_lat = 1'b1;
        exp_pc   = RESET_PC;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_addr = '0;
        nh = 0;
        for (int c = 0; c < 2000; c++) begin
            step();
            out_ready = ($urandom_range(0, 3) != 0);
            fetch_en  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'($urandom_range(0, 4095));
            end else begin
                redirect_valid = 1'b0;
            end
            #1;
            if (redirect_valid) begin
                check("rnd_redir_mask", out_valid, 0);
                exp_pc = redirect_pc & ~32'h3;
            end else if (out_valid && out_ready) begin
                ew = mem_word(exp_pc, 2);
                check("rnd_pc_out", pc_out, exp_pc);
                check("rnd_pc_link", pc_link, exp_pc + 32'h4);
                check("rnd_instr", instr, ew);
                check("rnd_opcode", opcode, ew[31:26]);
                check("rnd_func", func, ew[4:0]);
                check("rnd_rs", rs, ew[25:21]);
                check("rnd_rt", rt, ew[20:16]);
                check("rnd_imm16", imm16, ew[15:0]);
                check("rnd_label26", label26, ew[25:0]);
                exp_pc = exp_pc + 32'h4;
                nh++;
            end
            if (imem_req) check("rnd_addr_align", imem_addr[1:0], 0);
            if (prev_req && !prev_ack) begin
                check("rnd_req_held", imem_req, 1);
                check("rnd_addr_stable", imem_addr, prev_addr);
            end
            prev_req  = imem_req;
            prev_ack  = imem_ack;
            prev_addr = imem_addr;
        end
        check("rnd_progress", (nh >= 20), 1);
        rand_lat       = 1'b0;
        redirect_valid = 1'b0;

`ifdef IFU_PERF_CNT_EN
        // ---------------- Performance counters ----------------
        do_reset();
        check("perf_rst_retired", retired_cnt, 0);
        check("perf_rst_squash", squash_cnt, 0);
        mem_mode  = 0;
        ack_lat   = 0;
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        nh = 0;
        for (int c = 0; c < 40 && nh < 3; c++) begin
            step();
            #1;
            if (out_valid && out_ready) nh++;
        end
        check("perf_three_retired", nh, 3);
        step();
        out_ready = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            #1;
            found = out_valid;
        end
        check("perf_reach_hold", found, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        for (int c = 0; c < 6; c++) step();
        check("perf_retired", retired_cnt, 3);
        check("perf_squash", squash_cnt, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
